// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder:
// FSM state encodings, storage depth, request address width and reset data value.
package dmem_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam int unsigned DMEM_DEPTH = 16;
   localparam int unsigned REQ_ADDR_W = 16;

   localparam logic [15:0] DMEM_RESET_DATA = 16'h0000;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory
// responder (slave).
interface data_mem_responder_if #(
   parameter int unsigned DATA_W = 16
);
   import dmem_pkg::*;

   logic                  req_valid;
   logic                  req_write;
   logic [REQ_ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic                  req_ready;
   logic                  busy;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, busy, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, busy, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// Data store for the responder: 2**ADDR_W x DATA_W words, cleared asynchronously,
// one synchronous access port. On an enabled write the written word is also
// loaded into the read register, so the port behaves write-first.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   // Next-state of storage and read register for a single access.
   always_comb begin
      mem_d   = mem_q;
      rdata_d = rdata_q;
      if (en) begin
         if (we) begin
            mem_d[addr] = wdata;
            rdata_d     = wdata;
         end else begin
            rdata_d = mem_q[addr];
         end
      end
   end

   // Storage and read register, all cleared by the async reset.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= DATA_W'(DMEM_RESET_DATA);
         end
         rdata_q <= '0;
      end else begin
         mem_q   <= mem_d;
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the MEM-stage data-memory interface: accepts one request per
// handshake, waits WAIT_CYCLES cycles, then returns a single-cycle response.
// Optional build macro ADDR_CHECK_EN: non-zero upper address bits raise rsp_err
// and suppress the write; without it upper bits alias and rsp_err is tied 0.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 clear,
   data_mem_responder_if.slave  bus
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              lat_write_q, lat_write_d;
   logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
   logic              lat_err_q, lat_err_d;

   logic              ready;
   logic              accept;
   logic              in_resp;
   logic              req_err;
   logic              mem_en;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

`ifdef ADDR_CHECK_EN
   assign req_err = |bus.req_addr[REQ_ADDR_W-1:ADDR_W];
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.req_addr[REQ_ADDR_W-1:ADDR_W];
   assign req_err        = 1'b0;
`endif

   assign ready   = (state_q == S_IDLE) | (state_q == S_RESP);
   assign accept  = bus.req_valid & ready;
   assign in_resp = (state_q == S_RESP);

   // FSM, wait down-counter and request latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lat_write_d = lat_write_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      lat_err_d   = lat_err_q;
      case (state_q)
         S_IDLE, S_RESP: begin
            if (accept) begin
               lat_write_d = bus.req_write;
               lat_addr_d  = bus.req_addr[ADDR_W-1:0];
               lat_wdata_d = bus.req_wdata;
               lat_err_d   = req_err;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The array is accessed on every edge that enters RESP. Using the *_d latch
   // values covers both the WAIT->RESP path and a zero-wait accept, where the
   // request is latched and serviced on the same edge.
   always_comb begin
      mem_en = (state_d == S_RESP);
      mem_we = mem_en & lat_write_d & ~lat_err_d;
   end

   // State, counter and request latch registers.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         lat_write_q <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         lat_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lat_write_q <= lat_write_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         lat_err_q   <= lat_err_d;
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .clear (clear),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (lat_addr_d),
      .wdata (lat_wdata_d),
      .rdata (mem_rdata)
   );

   assign bus.req_ready = ready;
   assign bus.busy      = (state_q == S_WAIT) | ((state_q == S_IDLE) & bus.req_valid);
   assign bus.rsp_valid = in_resp;
   assign bus.rsp_rdata = (in_resp & ~lat_err_q) ? mem_rdata : '0;
   assign bus.rsp_err   = in_resp & lat_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the responder.
module tb_data_mem_responder;
   import dmem_pkg::*;

   localparam int unsigned WC = 1;
`ifdef ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk   = 1'b0;
   logic clear = 1'b0;
   always #5 clk = ~clk;

   data_mem_responder_if #(.DATA_W(16)) bus();

   data_mem_responder #(
      .DATA_W      (16),
      .ADDR_W      (4),
      .WAIT_CYCLES (WC)
   ) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Model: outstanding transaction with edges remaining until its response cycle.
   logic [15:0] m_mem [DMEM_DEPTH];
   bit          m_out;
   int          m_rem;
   bit          m_w;
   logic [15:0] m_a;
   logic [15:0] m_d;
   logic [15:0] m_rdata;
   bit          m_err;
   bit          m_acc;
   int          m_acc_cyc;
   int          m_acc_total = 0;

   // Responses observed on the DUT.
   int          rsp_cycs  [$];
   logic [15:0] rsp_datas [$];
   logic        rsp_errs  [$];

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void timeout(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: no DUT event within bound (cycle %0d)", nm, cyc);
   endfunction

   function automatic void model_reset();
      foreach (m_mem[i]) m_mem[i] = 16'h0000;
      m_out   = 1'b0;
      m_rem   = 0;
      m_rdata = 16'h0000;
      m_err   = 1'b0;
      m_acc   = 1'b0;
   endfunction

   function automatic void model_commit();
      int idx;
      m_err = CHK && (m_a[15:4] != 12'h000);
      idx   = int'(m_a[3:0]);
      if (m_w && !m_err) m_mem[idx] = m_d;
      m_rdata = m_err ? 16'h0000 : (m_w ? m_d : m_mem[idx]);
   endfunction

   function automatic void model_edge();
      bit rdy;
      rdy   = !m_out || (m_rem == 0);
      m_acc = bus.req_valid && rdy;
      if (m_out && m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) model_commit();
      end else if (m_out) begin
         m_out = 1'b0;
      end
      if (m_acc) begin
         m_out = 1'b1;
         m_w   = bus.req_write;
         m_a   = bus.req_addr;
         m_d   = bus.req_wdata;
         m_rem = WC;
         m_acc_cyc = cyc;
         m_acc_total++;
         if (WC == 0) model_commit();
      end
   endfunction

   function automatic void check_cycle();
      bit rn;
      rn = m_out && (m_rem == 0);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(rn));
      chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(rn ? m_rdata : 16'h0000));
      chk("rsp_err",   32'(bus.rsp_err),   32'(rn ? m_err : 1'b0));
      chk("req_ready", 32'(bus.req_ready), 32'(!m_out || m_rem == 0));
      chk("busy",      32'(bus.busy),      32'((m_out && m_rem > 0) || (!m_out && bus.req_valid)));
      if (bus.rsp_valid === 1'b1) begin
         rsp_cycs.push_back(cyc);
         rsp_datas.push_back(bus.rsp_rdata);
         rsp_errs.push_back(bus.rsp_err);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      if (clear) model_edge();
      cyc++;
      @(negedge clk);
      check_cycle();
   endtask

   // Mid-cycle reset pulse; outputs must drop to idle immediately.
   task automatic pulse_clear();
      #2;
      bus.req_valid = 1'b0;
      clear = 1'b0;
      model_reset();
      #1;
      check_cycle();
      chk("clr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("clr_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
      chk("clr_busy",      32'(bus.busy),      32'd0);
      chk("clr_req_ready", 32'(bus.req_ready), 32'd1);
      tick();
      #2;
      clear = 1'b1;
   endtask

   task automatic request(input bit w, input logic [15:0] a, input logic [15:0] d, input bit drop);
      int n;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      n = 0;
      do begin
         tick();
         n++;
      end while (!m_acc && n < 20);
      if (!m_acc) timeout("accept_timeout");
      if (drop) bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int want);
      int n;
      n = 0;
      while (rsp_cycs.size() < want && n < 40) begin
         tick();
         n++;
      end
      if (rsp_cycs.size() < want) timeout("rsp_timeout");
   endtask

   task automatic read_expect(input string nm, input logic [15:0] a, input logic [15:0] exp);
      int n0;
      n0 = rsp_cycs.size();
      request(1'b0, a, 16'h0000, 1'b1);
      wait_rsp(n0 + 1);
      if (rsp_cycs.size() > n0) chk(nm, 32'(rsp_datas[n0]), 32'(exp));
   endtask

   initial begin
      int n0;
      int acc0;
      int n;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      model_reset();
      #12;
      check_cycle();
      chk("reset_ready", 32'(bus.req_ready), 32'd1);
      clear = 1'b1;

      // Reset behaviour and cleared storage.
      bus.req_valid = 1'b1;
      pulse_clear();
      read_expect("t1_read4", 16'h0004, 16'h0000);

      // Write with one wait state: latency, busy during WAIT, echoed data.
      n0 = rsp_cycs.size();
      request(1'b1, 16'h0003, 16'h1234, 1'b1);
      acc0 = m_acc_cyc;
      chk("t2_busy_wait", 32'(bus.busy), 32'd1);
      chk("t2_ready_wait", 32'(bus.req_ready), 32'd0);
      wait_rsp(n0 + 1);
      if (rsp_cycs.size() > n0) begin
         chk("t2_latency", 32'(rsp_cycs[n0] - acc0), 32'(WC + 1));
         chk("t2_wdata_echo", 32'(rsp_datas[n0]), 32'h1234);
      end

      // Reads after the write.
      read_expect("t3_read3", 16'h0003, 16'h1234);
      read_expect("t3_read5", 16'h0005, 16'h0000);

      // Back-to-back: read accepted in the RESP cycle of the write.
      n0 = rsp_cycs.size();
      request(1'b1, 16'h0007, 16'hBEEF, 1'b0);
      bus.req_write = 1'b0;
      bus.req_wdata = 16'h0000;
      n = 0;
      do begin
         tick();
         n++;
      end while (!m_acc && n < 20);
      bus.req_valid = 1'b0;
      wait_rsp(n0 + 2);
      if (rsp_cycs.size() > n0 + 1) begin
         chk("t4_first",   32'(rsp_datas[n0]), 32'hBEEF);
         chk("t4_second",  32'(rsp_datas[n0 + 1]), 32'hBEEF);
         chk("t4_spacing", 32'(rsp_cycs[n0 + 1] - rsp_cycs[n0]), 32'(WC + 1));
         chk("t4_acc_in_resp", 32'(m_acc_cyc), 32'(rsp_cycs[n0]));
      end

      // Reset during WAIT discards the write and its response.
      n0 = rsp_cycs.size();
      request(1'b1, 16'h0002, 16'hAAAA, 1'b1);
      pulse_clear();
      repeat (4) tick();
      chk("t5_no_rsp", 32'(rsp_cycs.size()), 32'(n0));
      read_expect("t5_read2", 16'h0002, 16'h0000);

      // Upper address bits.
      n0 = rsp_cycs.size();
      request(1'b1, 16'h0013, 16'h5555, 1'b1);
      wait_rsp(n0 + 1);
`ifdef ADDR_CHECK_EN
      if (rsp_cycs.size() > n0) begin
         chk("t6_err",   32'(rsp_errs[n0]),  32'd1);
         chk("t6_rdata", 32'(rsp_datas[n0]), 32'h0000);
      end
      read_expect("t6_read3", 16'h0003, 16'h0000);
`else
      if (rsp_cycs.size() > n0) begin
         chk("t6_err",   32'(rsp_errs[n0]),  32'd0);
         chk("t6_rdata", 32'(rsp_datas[n0]), 32'h5555);
      end
      read_expect("t6_read3", 16'h0003, 16'h5555);
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         if (!bus.req_valid || m_acc) begin
            if ($urandom_range(2, 0) != 0) begin
               bus.req_valid = 1'b1;
               bus.req_write = 1'($urandom_range(1, 0));
               bus.req_addr  = ($urandom_range(4, 0) == 0) ? 16'($urandom) : 16'($urandom_range(15, 0));
               bus.req_wdata = 16'($urandom);
            end else begin
               bus.req_valid = 1'b0;
            end
         end
         if ($urandom_range(79, 0) == 0) pulse_clear();
         tick();
      end
      bus.req_valid = 1'b0;
      repeat (WC + 3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
